// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types for the sequenced ALU: the operation encoding, the bit
//   positions inside the 4-bit flag word {N,V,C,Z}, and a small helper that
//   assembles a flag word from a result plus its carry/overflow bits.
package alu_seq_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [3:0] {
      ALU_NONE = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_NOT  = 4'd6,
      ALU_SHL  = 4'd7,
      ALU_SHR  = 4'd8,
      ALU_MUL  = 4'd9
   } alu_op_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   // Z and N always follow the result; C and V are supplied by the operation.
   function automatic logic [3:0] make_flags(input logic [ALU_WIDTH-1:0] r,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (r == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_N] = r[ALU_WIDTH-1];
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Control/operand bundle between the sequencer (master) and the ALU (slave).
//   acc   : operand A from the accumulator register
//   in    : operand B from the data bus
//   op    : requested operation, sampled with start in IDLE
//   start : start request
//   oe    : output enable for the tri-state result driver
//   flags : registered {N,V,C,Z}
//   busy  : ALU not in IDLE
//   done  : one-cycle completion pulse
interface alu_seq_if;
   import alu_seq_pkg::*;

   logic [7:0] acc;
   logic [7:0] in;
   alu_op_e    op;
   logic       start;
   logic       oe;
   logic [3:0] flags;
   logic       busy;
   logic       done;

   modport master (output acc, in, op, start, oe, input  flags, busy, done);
   modport slave  (input  acc, in, op, start, oe, output flags, busy, done);

endinterface

// File: rtl/alu_comb.sv
// alu_comb
//   Single-cycle part of the ALU: add, subtract and bitwise logic, with the
//   flag word that goes with each result.
//   a, b   : operands (NOT uses a only)
//   op     : operation; anything else yields a zero result
//   result : combinational result
//   flags  : combinational {N,V,C,Z} for result
module alu_comb
   import alu_seq_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  alu_op_e    op,
   output logic [7:0] result,
   output logic [3:0] flags
);

   logic [8:0] sum;
   logic [7:0] r;
   logic       c;
   logic       v;

   always_comb begin
      sum = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         ALU_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[7:0];
            c   = sum[8];
            // Overflow: same-sign operands producing an opposite-sign sum.
            v   = (a[7] == b[7]) && (r[7] != a[7]);
         end
         ALU_SUB: begin
            r = a - b;
            c = (a < b);   // borrow
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_NOT: r = ~a;
         default: r = '0;
      endcase
      result = r;
      flags  = make_flags(r, c, v);
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Sequenced 8-bit ALU. Single-cycle ops finish on the start edge; shifts
//   move one bit per clock; multiply is an 8-step shift-add.
//   clock : posedge clock
//   reset : asynchronous active-high reset
//   bus   : operand/control bundle (slave side)
//   out   : result register when bus.oe=1, otherwise released ('z)
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH     = 8,   // only 8 is supported
   parameter int MUL_STEPS = 8    // must equal WIDTH
)(
   input  logic        clock,
   input  logic        reset,
   alu_seq_if.slave    bus,
   output wire  [WIDTH-1:0] out
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;

   state_e             state_reg,  state_next;
   alu_op_e            op_reg,     op_next;
   logic [WIDTH-1:0]   a_reg,      a_next;
   logic [WIDTH-1:0]   result_reg, result_next;
   logic [3:0]         flags_reg,  flags_next;
   logic [3:0]         count_reg,  count_next;
   // Product accumulator: upper half collects partial sums, lower half
   // starts as operand B and is consumed one multiplier bit per step.
   logic [2*WIDTH-1:0] prod_reg,   prod_next;

   logic [WIDTH-1:0]   comb_result;
   logic [3:0]         comb_flags;
   logic [WIDTH-1:0]   shift_val;
   logic               shift_c;
   logic [WIDTH:0]     mul_sum;

   alu_comb u_comb (
      .a      (bus.acc),
      .b      (bus.in),
      .op     (bus.op),
      .result (comb_result),
      .flags  (comb_flags)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         op_reg     <= ALU_NONE;
         a_reg      <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
         count_reg  <= '0;
         prod_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         a_reg      <= a_next;
         result_reg <= result_next;
         flags_reg  <= flags_next;
         count_reg  <= count_next;
         prod_reg   <= prod_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      a_next      = a_reg;
      result_next = result_reg;
      flags_next  = flags_reg;
      count_next  = count_reg;
      prod_next   = prod_reg;
      shift_val   = '0;
      shift_c     = 1'b0;
      mul_sum     = '0;

      case (state_reg)
         S_IDLE: begin
            if (bus.start && (bus.op != ALU_NONE)) begin
               a_next  = bus.acc;
               op_next = bus.op;
               case (bus.op)
                  ALU_SHL, ALU_SHR: begin
                     result_next = bus.acc;
                     count_next  = {1'b0, bus.in[2:0]};
                     if (bus.in[2:0] == 3'd0) begin
                        flags_next = make_flags(bus.acc, 1'b0, 1'b0);
                        state_next = S_DONE;
                     end else begin
                        state_next = S_SHIFT;
                     end
                  end
                  ALU_MUL: begin
                     result_next = '0;
                     count_next  = 4'(MUL_STEPS);
                     prod_next   = {{WIDTH{1'b0}}, bus.in};
                     state_next  = S_MUL;
                  end
                  default: begin
                     result_next = comb_result;
                     flags_next  = comb_flags;
                     state_next  = S_DONE;
                  end
               endcase
            end
         end

         S_SHIFT: begin
            if (op_reg == ALU_SHL) begin
               shift_val = {result_reg[WIDTH-2:0], 1'b0};
               shift_c   = result_reg[WIDTH-1];
            end else begin
               shift_val = {1'b0, result_reg[WIDTH-1:1]};
               shift_c   = result_reg[0];
            end
            result_next = shift_val;
            count_next  = count_reg - 4'd1;
            // Only the last bit shifted out survives into C.
            if (count_reg == 4'd1) begin
               flags_next = make_flags(shift_val, shift_c, 1'b0);
               state_next = S_DONE;
            end
         end

         S_MUL: begin
            mul_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                       + (prod_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
            prod_next  = {mul_sum, prod_reg[WIDTH-1:1]};
            count_next = count_reg - 4'd1;
            if (count_reg == 4'd1) begin
               result_next = prod_next[WIDTH-1:0];
               flags_next  = make_flags(prod_next[WIDTH-1:0],
                                        |prod_next[2*WIDTH-1:WIDTH], 1'b0);
               state_next  = S_DONE;
            end
         end

         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.busy  = (state_reg != S_IDLE);
   assign bus.done  = (state_reg == S_DONE);
   assign bus.flags = flags_reg;
   assign out       = bus.oe ? result_reg : 'z;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   wire  [7:0] out;
   int         checks   = 0;
   int         failures = 0;

   alu_seq_if bus ();

   alu_seq dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .out   (out)
   );

   always #5 clock = ~clock;

   typedef struct {
      alu_op_e    op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      logic [3:0] exp_flags;   // {N,V,C,Z}
      int         exp_lat;     // edges from the start edge (1) to done
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference behaviour from the arithmetic rules, not the FSM.
   function automatic void model(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [3:0] f, output int lat);
      int ia, ib, s, n;
      logic c, v;
      logic [15:0] w;
      ia = int'(a); ib = int'(b);
      c = 1'b0; v = 1'b0; lat = 1; r = '0;
      n = ib % 8;
      case (op)
         ALU_ADD: begin
            s = ia + ib; r = 8'(s); c = (s > 255);
            s = int'($signed(a)) + int'($signed(b)); v = (s > 127) || (s < -128);
         end
         ALU_SUB: begin
            s = ia - ib; r = 8'(s); c = (ia < ib);
            s = int'($signed(a)) - int'($signed(b)); v = (s > 127) || (s < -128);
         end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_NOT: r = ~a;
         ALU_SHL: begin
            w = 16'(ia) << n; r = w[7:0];
            if (n != 0) c = w[8];
            lat = n + 1;
         end
         ALU_SHR: begin
            r = 8'(ia >> n);
            if (n != 0) c = 1'(ia >> (n - 1));
            lat = n + 1;
         end
         ALU_MUL: begin
            s = ia * ib; r = 8'(s); c = (s > 255); lat = 9;
         end
         default: r = '0;
      endcase
      f = {r[7], v, c, (r == 8'h00)};
   endfunction

   // Issue one op when the ALU is idle; report latency (0 = never finished),
   // the out value (oe=1) and the flags seen in the done cycle.
   task automatic do_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                        input bit noise, output int lat, output logic [7:0] res,
                        output logic [3:0] fl);
      int w;
      w = 0;
      @(negedge clock);
      while (bus.busy && w < 50) begin
         @(negedge clock);
         w++;
      end
      bus.acc = a; bus.in = b; bus.op = op; bus.start = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clock);
         #1;
         if (k == 1) begin
            // Scramble the inputs so latched operands are what gets used.
            bus.start = 1'b0;
            bus.acc   = 8'($urandom);
            bus.in    = 8'($urandom);
            bus.op    = noise ? ALU_ADD : ALU_NONE;
         end else begin
            bus.start = noise && (k <= 6);
         end
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      bus.start = 1'b0;
      bus.op    = ALU_NONE;
      res = out;
      fl  = bus.flags;
      $display("op=%s a=%02h b=%02h out=%02h flags=%04b lat=%0d", op.name(), a, b, res, fl, lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vecs[$];
      int         lat, elat;
      logic [7:0] res, eres;
      logic [3:0] fl, efl;
      alu_op_e    rop;

      vecs.push_back('{ALU_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1});
      vecs.push_back('{ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100, 1});
      vecs.push_back('{ALU_SHL, 8'hA1, 8'h03, 8'h08, 4'b0010, 4});
      vecs.push_back('{ALU_SHL, 8'hA1, 8'h00, 8'hA1, 4'b1000, 1});
      vecs.push_back('{ALU_MUL, 8'h10, 8'h11, 8'h10, 4'b0010, 9});
      vecs.push_back('{ALU_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 9});
      vecs.push_back('{ALU_SHR, 8'h81, 8'h01, 8'h40, 4'b0010, 2});
      vecs.push_back('{ALU_SHR, 8'h80, 8'h07, 8'h01, 4'b0000, 8});
      vecs.push_back('{ALU_AND, 8'hF0, 8'h0F, 8'h00, 4'b0001, 1});
      vecs.push_back('{ALU_OR,  8'h80, 8'h01, 8'h81, 4'b1000, 1});
      vecs.push_back('{ALU_NOT, 8'h0F, 8'h55, 8'hF0, 4'b1000, 1});
      vecs.push_back('{ALU_SUB, 8'h01, 8'h02, 8'hFF, 4'b1010, 1});
      vecs.push_back('{ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1});
      vecs.push_back('{ALU_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1});

      // Reset state
      reset = 1'b1;
      bus.acc = '0; bus.in = '0; bus.op = ALU_NONE; bus.start = 1'b0; bus.oe = 1'b1;
      repeat (2) @(negedge clock);
      check("reset_busy",  32'(bus.busy),  0);
      check("reset_done",  32'(bus.done),  0);
      check("reset_flags", 32'(bus.flags), 0);
      check("reset_out",   32'(out),       0);
      reset = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, res, fl);
         check($sformatf("vec%0d_%s_res",   i, vecs[i].op.name()), 32'(res), 32'(vecs[i].exp_res));
         check($sformatf("vec%0d_%s_flags", i, vecs[i].op.name()), 32'(fl),  32'(vecs[i].exp_flags));
         check($sformatf("vec%0d_%s_lat",   i, vecs[i].op.name()), 32'(lat), 32'(vecs[i].exp_lat));
      end

      // Output enable released, then re-enabled without disturbing the result
      do_op(ALU_OR, 8'h80, 8'h01, 1'b0, lat, res, fl);
      bus.oe = 1'b0;
      #1;
      check("oe0_released", 32'(out === 8'h81), 0);
      bus.oe = 1'b1;
      #1;
      check("oe1_out", 32'(out), 32'h81);

      // Start pulses while a multiply is busy are ignored
      do_op(ALU_MUL, 8'h10, 8'h11, 1'b1, lat, res, fl);
      check("mul_noise_lat",   32'(lat), 9);
      check("mul_noise_res",   32'(res), 32'h10);
      check("mul_noise_flags", 32'(fl),  32'b0010);

      // Asynchronous reset in the middle of a multiply
      do_op(ALU_OR, 8'h80, 8'h01, 1'b0, lat, res, fl);
      check("pre_reset_flags", 32'(fl), 32'b1000);
      repeat (2) @(negedge clock);
      bus.acc = 8'h10; bus.in = 8'h11; bus.op = ALU_MUL; bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0; bus.op = ALU_NONE;
      repeat (2) @(posedge clock);
      #1;
      check("mid_mul_busy", 32'(bus.busy), 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_busy",  32'(bus.busy),  0);
      check("async_rst_done",  32'(bus.done),  0);
      check("async_rst_flags", 32'(bus.flags), 0);
      check("async_rst_out",   32'(out),       0);
      @(negedge clock);
      reset = 1'b0;
      do_op(ALU_MUL, 8'h03, 8'h05, 1'b0, lat, res, fl);
      check("post_rst_mul_lat", 32'(lat), 9);
      check("post_rst_mul_res", 32'(res), 32'h0F);

      // Back-to-back XOR then NOT with start held high
      repeat (2) @(negedge clock);
      bus.acc = 8'h0F; bus.in = 8'hF0; bus.op = ALU_XOR; bus.start = 1'b1;
      @(posedge clock);
      #1;
      check("b2b_xor_done",  32'(bus.done),  1);
      check("b2b_xor_flags", 32'(bus.flags), 32'b1000);
      bus.acc = 8'hFF; bus.op = ALU_NOT;
      @(posedge clock);
      #1;
      check("b2b_ignored_in_done", 32'(bus.done),  0);
      check("b2b_idle_busy",       32'(bus.busy),  0);
      check("b2b_flags_persist",   32'(bus.flags), 32'b1000);
      check("b2b_out_persist",     32'(out),       32'hFF);
      @(posedge clock);
      #1;
      bus.start = 1'b0; bus.op = ALU_NONE;
      check("b2b_not_done",  32'(bus.done),  1);
      check("b2b_not_flags", 32'(bus.flags), 32'b0001);
      check("b2b_not_out",   32'(out),       32'h00);
      $display("op=XOR/NOT back-to-back out=%02h flags=%04b", out, bus.flags);

      // Randomized ops against the reference model
      for (int t = 0; t < 40; t++) begin
         rop = alu_op_e'($urandom_range(1, 9));
         res = 8'($urandom); eres = 8'($urandom);
         model(rop, res, eres, eres, efl, elat);
         begin
            logic [7:0] ra, rb;
            ra = 8'($urandom); rb = 8'($urandom);
            model(rop, ra, rb, eres, efl, elat);
            do_op(rop, ra, rb, 1'b0, lat, res, fl);
            check($sformatf("rnd%0d_%s_res",   t, rop.name()), 32'(res), 32'(eres));
            check($sformatf("rnd%0d_%s_flags", t, rop.name()), 32'(fl),  32'(efl));
            check($sformatf("rnd%0d_%s_lat",   t, rop.name()), 32'(lat), 32'(elat));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
